// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter/sequencer for one shared combinational logic_unit
module logic_unit_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 64,
   parameter int IDW   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ*3-1:0]       req_sel,
   output logic [WIDTH-1:0]        lu_a,
   output logic [WIDTH-1:0]        lu_b,
   output logic [2:0]              lu_sel,
   input  logic [WIDTH-1:0]        lu_res,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [IDW-1:0]          resp_id,
   output logic [WIDTH-1:0]        resp_res,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] id_reg;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] ptr_nxt;
   logic           found;
   int             idx;

   // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
   end

   assign ptr_nxt = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
   assign busy    = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and the one-cycle grant strobe; nothing is granted while reset is held
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt         = EXEC;
               req_ready[winner] = 1'b1;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!rst_n) req_ready = '0;
   end

   // Operand capture at grant, result capture after the single EXEC cycle, response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= '0;
         id_reg     <= '0;
         lu_a       <= '0;
         lu_b       <= '0;
         lu_sel     <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_res   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  lu_a   <= req_a[winner*WIDTH +: WIDTH];
                  lu_b   <= req_b[winner*WIDTH +: WIDTH];
                  lu_sel <= req_sel[winner*3 +: 3];
                  id_reg <= winner;
                  ptr    <= ptr_nxt;
               end
            end
            EXEC: begin
               resp_res   <= lu_res;
               resp_id    <= id_reg;
               resp_valid <= 1'b1;
            end
            RESP: begin
               if (resp_ready) resp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized self-checking bench for logic_unit_arbiter
module tb_logic_unit_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 64;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*3-1:0]     req_sel;
   logic [WIDTH-1:0]      lu_a;
   logic [WIDTH-1:0]      lu_b;
   logic [2:0]            lu_sel;
   logic [WIDTH-1:0]      lu_res;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [WIDTH-1:0]      resp_res;
   logic                  busy;

   always #5 clk = ~clk;

   assign lu_res = lu_a ^ lu_b ^ {{(WIDTH-3){1'b0}}, lu_sel};

   logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_res(lu_res),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_res(resp_res), .busy(busy)
   );

   typedef struct {
      int               id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       sel;
   } txn_t;

   txn_t             q[$];
   txn_t             t;
   int               grant_log[$];
   int               grant_cyc[$];
   int               n_checks = 0;
   int               n_errors = 0;
   int               m_ptr = 0;
   bit               m_busy = 0;
   int               m_cnt = 0;
   int               mw;
   int               n_grants = 0;
   int               resp_count = 0;
   int               cyc = 0;
   logic [NREQ-1:0]  er;
   logic [NREQ-1:0]  granted = '0;
   logic [NREQ-1:0]  keep_mask = '0;
   bit               rand_mode = 0;
   logic [WIDTH-1:0] last_res = '0;
   int               last_id = -1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      int w;
      int j;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         j = (p + k) % NREQ;
         if (w < 0 && v[j]) w = j;
      end
      return w;
   endfunction

   function automatic logic [WIDTH-1:0] op_result(input txn_t x);
      return x.a ^ x.b ^ {{(WIDTH-3){1'b0}}, x.sel};
   endfunction

   // Transaction-level reference: at most one transaction outstanding, round-robin winner,
   // result two edges after the grant, held until accepted
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         check("busy", busy, m_busy);
         if (!m_busy) begin
            check("resp_valid_idle", resp_valid, 0);
            mw = pick(req_valid, m_ptr);
            er = '0;
            if (mw >= 0) er[mw] = 1'b1;
            check("req_ready", req_ready, er);
            if (mw >= 0) begin
               t.id  = mw;
               t.a   = req_a[mw*WIDTH +: WIDTH];
               t.b   = req_b[mw*WIDTH +: WIDTH];
               t.sel = req_sel[mw*3 +: 3];
               q.push_back(t);
               m_ptr  = (mw + 1) % NREQ;
               m_busy = 1;
               m_cnt  = 0;
               n_grants++;
               grant_log.push_back(mw);
               grant_cyc.push_back(cyc);
               granted[mw] = 1'b1;
            end
         end else begin
            check("req_ready_busy", req_ready, 0);
            m_cnt++;
            if (m_cnt == 1) begin
               check("resp_valid_exec", resp_valid, 0);
               check("lu_a", lu_a, q[0].a);
               check("lu_b", lu_b, q[0].b);
               check("lu_sel", lu_sel, q[0].sel);
            end else begin
               check("resp_valid", resp_valid, 1);
               check("resp_id", resp_id, q[0].id);
               check("resp_res", resp_res, op_result(q[0]));
               if (resp_ready) begin
                  last_res = resp_res;
                  last_id  = resp_id;
                  void'(q.pop_front());
                  m_busy = 0;
                  resp_count++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(granted & ~keep_mask);
      granted   = '0;
      if (rand_mode) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_a[i*WIDTH +: WIDTH] = {$urandom, $urandom};
               req_b[i*WIDTH +: WIDTH] = {$urandom, $urandom};
               req_sel[i*3 +: 3]       = 3'($urandom_range(0, 7));
               req_valid[i]            = 1'b1;
            end
         end
         resp_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] s);
      req_a[i*WIDTH +: WIDTH] = a;
      req_b[i*WIDTH +: WIDTH] = b;
      req_sel[i*3 +: 3]       = s;
      req_valid[i]            = 1'b1;
   endtask

   task automatic wait_grants(input int target);
      int k;
      k = 0;
      while (n_grants < target && k < 40) begin
         tick();
         k++;
      end
      check("grant_timeout", n_grants >= target, 1);
   endtask

   task automatic wait_resps(input int target);
      int k;
      k = 0;
      while (resp_count < target && k < 40) begin
         tick();
         k++;
      end
      check("resp_timeout", resp_count >= target, 1);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((m_busy || req_valid != '0) && k < 200) begin
         tick();
         k++;
      end
      check("idle_timeout", m_busy || req_valid != '0, 0);
   endtask

   task automatic release_reset();
      req_valid = '0;
      granted   = '0;
      m_ptr     = 0;
      m_busy    = 0;
      m_cnt     = 0;
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      release_reset();
   endtask

   logic [WIDTH-1:0] exp_bp;
   logic [WIDTH-1:0] a_bp;
   logic [WIDTH-1:0] b_bp;
   logic [2:0]       s_bp;
   int               g0;
   int               r0;

   initial begin
      rst_n      = 1'b0;
      req_valid  = 4'b0010;
      req_a      = '0;
      req_b      = '0;
      req_sel    = '0;
      resp_ready = 1'b0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_res", resp_res, 0);
      check("rst_lu_a", lu_a, 0);
      check("rst_lu_b", lu_b, 0);
      check("rst_lu_sel", lu_sel, 0);
      check("rst_req_ready", req_ready, 0);
      release_reset();

      // single request, no backpressure
      resp_ready = 1'b1;
      set_req(2, 64'd5, 64'd3, 3'd6);
      wait_resps(1);
      check("single_id", last_id, 2);
      check("single_res", last_res, 64'h0);
      wait_idle();

      // all requesters continuously valid
      apply_reset();
      grant_log.delete();
      grant_cyc.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, 64'(i), 64'd0, 3'd0);
      keep_mask = '1;
      repeat (26) tick();
      keep_mask = '0;
      req_valid = '0;
      wait_idle();
      check("rr_count", grant_log.size() >= 8, 1);
      for (int k = 0; k < grant_log.size(); k++) begin
         check("rr_order", grant_log[k], k % NREQ);
         if (k > 0) check("rr_gap", grant_cyc[k] - grant_cyc[k-1], 3);
      end

      // backpressure
      resp_ready = 1'b0;
      a_bp = {$urandom, $urandom};
      b_bp = {$urandom, $urandom};
      s_bp = 3'($urandom_range(0, 7));
      exp_bp = a_bp ^ b_bp ^ {61'b0, s_bp};
      g0 = n_grants;
      set_req(1, a_bp, b_bp, s_bp);
      wait_grants(g0 + 1);
      tick();
      set_req(0, 64'd9, 64'd4, 3'd1);
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", resp_valid, 1);
         check("bp_id", resp_id, 1);
         check("bp_res", resp_res, exp_bp);
         check("bp_busy", busy, 1);
         check("bp_ready", req_ready, 0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      check("bp_done", resp_valid, 0);
      wait_idle();

      // pointer wrap
      apply_reset();
      set_req(3, 64'd1, 64'd2, 3'd3);
      wait_idle();
      g0 = n_grants;
      set_req(1, 64'd7, 64'd7, 3'd0);
      set_req(3, 64'd8, 64'd0, 3'd5);
      wait_grants(g0 + 1);
      check("wrap_first", grant_log[$], 1);
      wait_grants(g0 + 2);
      check("wrap_second", grant_log[$], 3);
      wait_idle();

      // reset during EXEC
      g0 = n_grants;
      set_req(2, 64'hA5, 64'h5A, 3'd2);
      wait_grants(g0 + 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_resp_valid", resp_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_lu_a", lu_a, 0);
      check("mid_rst_lu_b", lu_b, 0);
      check("mid_rst_lu_sel", lu_sel, 0);
      release_reset();
      r0 = resp_count;
      repeat (4) tick();
      check("mid_rst_no_resp", resp_count, r0);
      g0 = n_grants;
      set_req(1, 64'd3, 64'd1, 3'd0);
      set_req(3, 64'd4, 64'd1, 3'd0);
      wait_grants(g0 + 1);
      check("mid_rst_ptr", grant_log[$], 1);
      wait_idle();

      // full-width data
      r0 = resp_count;
      set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd7);
      wait_resps(r0 + 1);
      check("full_width", last_res, 64'hFFFF_FFFF_FFFF_FFF8);
      wait_idle();

      // randomized traffic with random backpressure
      rand_mode = 1;
      repeat (400) tick();
      rand_mode  = 0;
      resp_ready = 1'b1;
      wait_idle();
      check("queue_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
